// File: rtl/window_ctrl_if.sv
// Window-addressed register-file port plus word-wide memory port used by window_ctrl.
// master = spill/fill controller, slave = regfile/memory side.
interface window_ctrl_if;
  logic        rf_rd_en;
  logic        rf_wr_en;
  logic [4:0]  rf_win;
  logic [3:0]  rf_idx;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output rf_rd_en, rf_wr_en, rf_win, rf_idx, rf_wdata,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  rf_rdata, mem_ready, mem_rdata
  );

  modport slave (
    input  rf_rd_en, rf_wr_en, rf_win, rf_idx, rf_wdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output rf_rdata, mem_ready, mem_rdata
  );
endinterface

// File: rtl/window_ctrl.sv
// Register-window save/restore controller: spills or fills one window on overflow/underflow.
// Latency 1 cycle when no trap, else 2*WIN_REGS+1 plus mem stalls; mem_ready low holds outputs.
module window_ctrl #(
  parameter int NWINDOWS = 8,
  parameter int WIN_REGS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         save_req,
  input  logic         restore_req,
  output logic         busy,
  input  logic [4:0]   cwp_in,
  input  logic [31:0]  wim_in,
  input  logic [31:0]  base_addr,
  output logic         cwp_inc,
  output logic         cwp_dec,
  output logic         wim_wr_en,
  output logic [31:0]  wim_wr_data,
  output logic         done,
  window_ctrl_if.master rf_mem
);

  localparam logic [4:0] WMASK = 5'(NWINDOWS - 1);
  localparam logic [3:0] LAST  = 4'(WIN_REGS - 1);

  typedef enum logic [2:0] {IDLE, SP_RD, SP_WR, FL_RD, FL_WR, FINISH} state_t;

  state_t      state, state_nx;
  logic [4:0]  v_q;
  logic [3:0]  cnt_q;
  logic [31:0] base_q;
  logic [31:0] data_q;
  logic        save_q;
  logic        xfer_q;
  logic        rd_pend_q;

  logic [4:0]  v_sel;
  logic [4:0]  wim_idx;
  logic        req;
  logic        last;
  logic [31:0] word_addr;

  logic        rf_rd_en_c, rf_wr_en_c, mem_valid_c, mem_we_c;
  logic [4:0]  rf_win_c;
  logic [3:0]  rf_idx_c;
  logic [31:0] rf_wdata_c, mem_addr_c, mem_wdata_c;

  assign req       = save_req || restore_req;
  assign v_sel     = save_req ? ((cwp_in - 5'd1) & WMASK) : ((cwp_in + 5'd1) & WMASK);
  assign wim_idx   = save_q ? ((v_q - 5'd1) & WMASK) : ((v_q + 5'd1) & WMASK);
  assign last      = (cnt_q == LAST);
  assign word_addr = base_q + {26'd0, cnt_q, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q       <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      data_q    <= '0;
      save_q    <= 1'b0;
      xfer_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            v_q       <= v_sel;
            save_q    <= save_req;
            xfer_q    <= wim_in[v_sel];
            base_q    <= base_addr;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
          end
        end
        SP_RD: rd_pend_q <= 1'b1;
        SP_WR: begin
          // regfile data arrives during the first SP_WR cycle; hold it for the rest of the stall
          if (rd_pend_q) begin
            data_q    <= rf_mem.rf_rdata;
            rd_pend_q <= 1'b0;
          end
          if (rf_mem.mem_ready) cnt_q <= cnt_q + 4'd1;
        end
        FL_RD: if (rf_mem.mem_ready) data_q <= rf_mem.mem_rdata;
        FL_WR: cnt_q <= cnt_q + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = (state != IDLE);
    cwp_inc     = 1'b0;
    cwp_dec     = 1'b0;
    wim_wr_en   = 1'b0;
    wim_wr_data = '0;
    done        = 1'b0;
    rf_rd_en_c  = 1'b0;
    rf_wr_en_c  = 1'b0;
    rf_win_c    = '0;
    rf_idx_c    = '0;
    rf_wdata_c  = '0;
    mem_valid_c = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!wim_in[v_sel]) state_nx = FINISH;
          else if (save_req)  state_nx = SP_RD;
          else                state_nx = FL_RD;
        end
      end
      SP_RD: begin
        rf_rd_en_c = 1'b1;
        rf_win_c   = v_q;
        rf_idx_c   = cnt_q;
        state_nx   = SP_WR;
      end
      SP_WR: begin
        mem_valid_c = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = word_addr;
        mem_wdata_c = rd_pend_q ? rf_mem.rf_rdata : data_q;
        if (rf_mem.mem_ready) state_nx = last ? FINISH : SP_RD;
      end
      FL_RD: begin
        mem_valid_c = 1'b1;
        mem_addr_c  = word_addr;
        if (rf_mem.mem_ready) state_nx = FL_WR;
      end
      FL_WR: begin
        rf_wr_en_c = 1'b1;
        rf_win_c   = v_q;
        rf_idx_c   = cnt_q;
        rf_wdata_c = data_q;
        state_nx   = last ? FINISH : FL_RD;
      end
      FINISH: begin
        done        = 1'b1;
        cwp_dec     = save_q;
        cwp_inc     = !save_q;
        wim_wr_en   = xfer_q;
        wim_wr_data = xfer_q ? (32'd1 << wim_idx) : 32'd0;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rf_mem.rf_rd_en  = rf_rd_en_c;
  assign rf_mem.rf_wr_en  = rf_wr_en_c;
  assign rf_mem.rf_win    = rf_win_c;
  assign rf_mem.rf_idx    = rf_idx_c;
  assign rf_mem.rf_wdata  = rf_wdata_c;
  assign rf_mem.mem_valid = mem_valid_c;
  assign rf_mem.mem_we    = mem_we_c;
  assign rf_mem.mem_addr  = mem_addr_c;
  assign rf_mem.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl: scoreboard queues of expected memory and regfile traffic.
module tb_window_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        save_req, restore_req;
  logic        busy, cwp_inc, cwp_dec, wim_wr_en, done;
  logic [4:0]  cwp_in;
  logic [31:0] wim_in, base_addr, wim_wr_data;

  window_ctrl_if mif();

  window_ctrl #(.NWINDOWS(8), .WIN_REGS(16)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .cwp_in(cwp_in), .wim_in(wim_in), .base_addr(base_addr),
    .cwp_inc(cwp_inc), .cwp_dec(cwp_dec), .wim_wr_en(wim_wr_en),
    .wim_wr_data(wim_wr_data), .done(done), .rf_mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;
  typedef struct { logic [4:0] win; logic [3:0] idx; logic [31:0] data; } rfw_t;

  mem_t exp_mem[$];
  rfw_t exp_rf[$];
  int   passed = 0, failed = 0, total = 0;

  logic [31:0] rf_arr [8][16];
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  logic        was_stalled = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        rd_pend_tb = 1'b0;
  logic [31:0] rd_val;

  function automatic logic [31:0] rf_val(input int w, input int i);
    return 32'hA000_0000 | 32'(w << 8) | 32'(i);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h3C3C_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  assign mif.mem_rdata = mif.mem_we ? 32'd0 : mem_val(mif.mem_addr);
  assign mif.mem_ready = !(mif.mem_valid && stall_left != 0 && mif.mem_addr == stall_addr);

  // synchronous regfile model: data valid the cycle after rf_rd_en
  always @(negedge clk) begin
    rd_pend_tb = mif.rf_rd_en;
    rd_val     = rf_arr[mif.rf_win[2:0]][mif.rf_idx];
  end
  always @(posedge clk) if (rd_pend_tb) mif.rf_rdata <= rd_val;

  always @(posedge clk) begin
    #1;
    if (was_stalled && stall_left != 0) stall_left--;
  end

  always @(negedge clk) begin
    mem_t e;
    rfw_t r;
    if (reset) begin
      if (mif.mem_valid && mif.mem_ready) begin
        check("mem_expected", 32'(exp_mem.size() != 0), 1);
        if (exp_mem.size() != 0) begin
          e = exp_mem.pop_front();
          check("mem_we", 32'(mif.mem_we), 32'(e.we));
          check("mem_addr", mif.mem_addr, e.addr);
          if (e.we) check("mem_wdata", mif.mem_wdata, e.data);
        end
      end
      if (prev_stall && mif.mem_valid) begin
        check("stall_addr_stable", mif.mem_addr, prev_addr);
        check("stall_wdata_stable", mif.mem_wdata, prev_wdata);
      end
      if (mif.rf_wr_en) begin
        check("rf_expected", 32'(exp_rf.size() != 0), 1);
        if (exp_rf.size() != 0) begin
          r = exp_rf.pop_front();
          check("rf_win", 32'(mif.rf_win), 32'(r.win));
          check("rf_idx", 32'(mif.rf_idx), 32'(r.idx));
          check("rf_wdata", mif.rf_wdata, r.data);
        end
      end
    end
    prev_stall  = mif.mem_valid && !mif.mem_ready;
    was_stalled = prev_stall;
    prev_addr   = mif.mem_addr;
    prev_wdata  = mif.mem_wdata;
  end

  task automatic do_req(input logic sv, input logic rs, input logic [4:0] cwp,
                        input logic [31:0] wim, input logic [31:0] base,
                        input logic [31:0] st_addr, input int st_n, input logic poke);
    logic [4:0]  v;
    logic        xfer, got, stray;
    int          exp_k, done_k;
    logic [31:0] exp_wim, a;
    v       = sv ? ((cwp - 5'd1) & 5'd7) : ((cwp + 5'd1) & 5'd7);
    xfer    = wim[v];
    exp_k   = xfer ? 33 + st_n : 1;
    exp_wim = !xfer ? 32'd0 : sv ? (32'd1 << ((v - 5'd1) & 5'd7)) : (32'd1 << ((v + 5'd1) & 5'd7));
    if (xfer) begin
      for (int i = 0; i < 16; i++) begin
        a = base + 32'(4 * i);
        if (sv) exp_mem.push_back('{1'b1, a, rf_val(int'(v), i)});
        else begin
          exp_mem.push_back('{1'b0, a, 32'd0});
          exp_rf.push_back('{v, 4'(i), mem_val(a)});
        end
      end
    end
    @(posedge clk); #1;
    stall_addr = st_addr; stall_left = st_n;
    save_req = sv; restore_req = rs; cwp_in = cwp; wim_in = wim; base_addr = base;
    @(posedge clk); #1;
    save_req = 1'b0; restore_req = 1'b0;
    cwp_in = ~cwp; wim_in = ~wim; base_addr = ~base;
    got = 1'b0; stray = 1'b0; done_k = 0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(negedge clk);
      if (poke && k == 10) begin save_req = 1'b1; restore_req = 1'b1; end
      if (poke && k == 11) begin save_req = 1'b0; restore_req = 1'b0; end
      if (done) begin
        got = 1'b1; done_k = k;
        check("done_latency", 32'(done_k), 32'(exp_k));
        check("busy_at_done", 32'(busy), 1);
        check("cwp_dec", 32'(cwp_dec), 32'(sv));
        check("cwp_inc", 32'(cwp_inc), 32'(!sv));
        check("wim_wr_en", 32'(wim_wr_en), 32'(xfer));
        check("wim_wr_data", wim_wr_data, exp_wim);
      end else begin
        stray = stray | cwp_dec | cwp_inc | wim_wr_en;
      end
    end
    check("done_seen", 32'(got), 1);
    check("no_early_pulse", 32'(stray), 0);
    @(negedge clk);
    check("busy_after", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
    @(negedge clk);
    check("not_requeued", 32'(busy), 0);
    check("mem_q_drained", 32'(exp_mem.size()), 0);
    check("rf_q_drained", 32'(exp_rf.size()), 0);
    exp_mem.delete(); exp_rf.delete();
  endtask

  initial begin
    logic found, stray;
    for (int w = 0; w < 8; w++)
      for (int i = 0; i < 16; i++) rf_arr[w][i] = rf_val(w, i);
    reset = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    cwp_in = '0; wim_in = '0; base_addr = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_pulses", 32'({cwp_dec, cwp_inc, wim_wr_en, done, mif.rf_rd_en, mif.rf_wr_en, mif.mem_valid}), 0);
    check("reset_mem_addr", mif.mem_addr, 0);
    reset = 1'b1;

    do_req(1'b1, 1'b0, 5'd3, 32'h01, 32'h1000, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b1, 1'b0, 5'd3, 32'h04, 32'h1000, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b0, 1'b1, 5'd7, 32'h01, 32'h4000, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b1, 1'b1, 5'd3, 32'h00, 32'h1000, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b1, 1'b0, 5'd0, 32'h80, 32'h2000, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b0, 1'b1, 5'd6, 32'h80, 32'h5000, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b1, 1'b0, 5'd3, 32'h04, 32'h1000, 32'h1010, 5, 1'b1);

    // abort a spill while word 7 is stalled in the memory handshake
    for (int i = 0; i < 16; i++)
      exp_mem.push_back('{1'b1, 32'h3000 + 32'(4 * i), rf_val(2, i)});
    @(posedge clk); #1;
    stall_addr = 32'h301C; stall_left = 1000;
    save_req = 1'b1; cwp_in = 5'd3; wim_in = 32'h04; base_addr = 32'h3000;
    @(posedge clk); #1;
    save_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (mif.mem_valid && mif.mem_addr == 32'h301C) found = 1'b1;
    end
    check("abort_reached_word7", 32'(found), 1);
    check("abort_wdata_word7", mif.mem_wdata, rf_val(2, 7));
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_valid", 32'(mif.mem_valid), 0);
    check("abort_mem_addr", mif.mem_addr, 0);
    check("abort_mem_wdata", mif.mem_wdata, 0);
    check("abort_pulses", 32'({cwp_dec, cwp_inc, wim_wr_en, done, mif.rf_rd_en, mif.rf_wr_en, mif.mem_we}), 0);
    stall_left = 0;
    exp_mem.delete();
    stray = 1'b0;
    save_req = 1'b1; cwp_in = 5'd5; wim_in = 32'h0; base_addr = 32'h0;
    repeat (3) begin
      @(negedge clk);
      stray = stray | cwp_dec | cwp_inc | wim_wr_en | done | busy;
    end
    reset = 1'b1;
    check("abort_no_update", 32'(stray), 0);
    @(posedge clk); #1;
    save_req = 1'b0;
    @(negedge clk);
    check("first_edge_cwp_dec", 32'(cwp_dec), 1);
    check("first_edge_done", 32'(done), 1);
    check("first_edge_no_wim", 32'(wim_wr_en), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
